// File: rtl/rdn_layer_sched_if.sv
// Control bundle between the RDN layer scheduler and its datapath/environment.
// master: the scheduler (drives the layer controls and handshake outputs).
// slave : the datapath / heuristic unit / IRU side.
interface rdn_layer_sched_if #(
  parameter int NUM_A_NEURONS = 15,
  parameter int NUM_B_NEURONS = 30
);
  localparam int BW = $clog2(NUM_A_NEURONS);
  localparam int CW = $clog2(NUM_B_NEURONS);

  logic          weight_valid;
  logic          heu_out_valid;
  logic          iru_in_ready;
  logic          in_ready;
  logic          out_valid;
  logic          write_in;
  logic          rotate_in;
  logic          shift_out;
  logic          z_a_layer;
  logic          z_b_layer;
  logic          z_c_layer;
  logic          en_a_layer;
  logic          en_b_layer;
  logic          en_c_layer;
  logic [BW-1:0] b_src_sel;
  logic [CW-1:0] c_src_sel;
  logic          busy;

  modport master (
    input  weight_valid, heu_out_valid, iru_in_ready,
    output in_ready, out_valid, write_in, rotate_in, shift_out,
           z_a_layer, z_b_layer, z_c_layer,
           en_a_layer, en_b_layer, en_c_layer,
           b_src_sel, c_src_sel, busy
  );

  modport slave (
    output weight_valid, heu_out_valid, iru_in_ready,
    input  in_ready, out_valid, write_in, rotate_in, shift_out,
           z_a_layer, z_b_layer, z_c_layer,
           en_a_layer, en_b_layer, en_c_layer,
           b_src_sel, c_src_sel, busy
  );
endinterface

// File: rtl/rdn_layer_sched.sv
// RDN layer sequencer: accepts a window, streams it through layer A,
// serialises A->B and B->C, then hands the angle result to the IRU.
// Optional macro RDN_SCHED_PERF_EN adds frame_cnt / stall_cnt outputs.
module rdn_layer_sched #(
  parameter int IN_COLS       = 80,
  parameter int NUM_A_NEURONS = 15,
  parameter int NUM_B_NEURONS = 30
) (
  input  logic        clk,
  input  logic        rst,
`ifdef RDN_SCHED_PERF_EN
  output logic [31:0] frame_cnt,
  output logic [31:0] stall_cnt,
`endif
  rdn_layer_sched_if.master bus
);
  localparam int MAX_AB = (IN_COLS > NUM_A_NEURONS) ? IN_COLS : NUM_A_NEURONS;
  localparam int MAX_N  = (MAX_AB > NUM_B_NEURONS) ? MAX_AB : NUM_B_NEURONS;
  localparam int CNT_W  = $clog2(MAX_N);
  localparam int BW     = $clog2(NUM_A_NEURONS);
  localparam int CW     = $clog2(NUM_B_NEURONS);

  typedef enum logic [2:0] {IDLE, A_RUN, B_RUN, C_RUN, OUT} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic          in_ready, out_valid, write_in, rotate_in, shift_out;
  logic          z_layers, en_a, en_b, en_c;
  logic [BW-1:0] b_sel;
  logic [CW-1:0] c_sel;

  // State and shared phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    write_in   = 1'b0;
    rotate_in  = 1'b0;
    shift_out  = 1'b0;
    z_layers   = 1'b0;
    en_a       = 1'b0;
    en_b       = 1'b0;
    en_c       = 1'b0;
    b_sel      = '0;
    c_sel      = '0;
    case (state_reg)
      IDLE: begin
        in_ready = bus.weight_valid;
        cnt_next = '0;
        // An accept during reset would be discarded anyway, so no pulse
        if (bus.heu_out_valid && bus.weight_valid && !rst) begin
          write_in   = 1'b1;
          z_layers   = 1'b1;
          state_next = A_RUN;
        end
      end
      A_RUN: begin
        rotate_in = 1'b1;
        en_a      = 1'b1;
        if (cnt_reg == CNT_W'(IN_COLS - 1)) begin
          state_next = B_RUN;
          cnt_next   = '0;
        end
      end
      B_RUN: begin
        en_b  = 1'b1;
        b_sel = BW'(cnt_reg);
        if (cnt_reg == CNT_W'(NUM_A_NEURONS - 1)) begin
          state_next = C_RUN;
          cnt_next   = '0;
        end
      end
      C_RUN: begin
        en_c  = 1'b1;
        c_sel = CW'(cnt_reg);
        if (cnt_reg == CNT_W'(NUM_B_NEURONS - 1)) begin
          state_next = OUT;
          cnt_next   = '0;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        cnt_next  = '0;
        // Losing the weights in the same cycle voids the handshake
        if (bus.iru_in_ready && bus.weight_valid && !rst) begin
          shift_out  = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // Weights disappearing mid-frame abandons the frame
    if (state_reg != IDLE && !bus.weight_valid) begin
      state_next = IDLE;
      cnt_next   = '0;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.write_in   = write_in;
  assign bus.rotate_in  = rotate_in;
  assign bus.shift_out  = shift_out;
  assign bus.z_a_layer  = z_layers;
  assign bus.z_b_layer  = z_layers;
  assign bus.z_c_layer  = z_layers;
  assign bus.en_a_layer = en_a;
  assign bus.en_b_layer = en_b;
  assign bus.en_c_layer = en_c;
  assign bus.b_src_sel  = b_sel;
  assign bus.c_src_sel  = c_sel;
  assign bus.busy       = (state_reg != IDLE);

`ifdef RDN_SCHED_PERF_EN
  // Saturating frame and IRU-stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (shift_out && frame_cnt != 32'hFFFF_FFFF)
        frame_cnt <= frame_cnt + 32'd1;
      if (state_reg == OUT && !bus.iru_in_ready && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rdn_layer_sched.sv
// Bench for rdn_layer_sched: table of phase segments, hand-written timing
// sequence, and randomized traffic checked against a cycle-offset model.
module tb_rdn_layer_sched;
  localparam int IN_COLS = 80;
  localparam int NA      = 15;
  localparam int NB      = 30;
  localparam int LAT     = 1 + IN_COLS + NA + NB;  // 126

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdn_layer_sched_if #(.NUM_A_NEURONS(NA), .NUM_B_NEURONS(NB)) bus ();

`ifdef RDN_SCHED_PERF_EN
  logic [31:0] frame_cnt, stall_cnt;
  rdn_layer_sched #(.IN_COLS(IN_COLS), .NUM_A_NEURONS(NA), .NUM_B_NEURONS(NB)) dut (
    .clk(clk), .rst(rst), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt), .bus(bus));
`else
  rdn_layer_sched #(.IN_COLS(IN_COLS), .NUM_A_NEURONS(NA), .NUM_B_NEURONS(NB)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: "frame in flight" flag plus cycles elapsed since accept
  bit          m_busy = 0;
  int          m_e    = 0;
  logic [31:0] m_frame = 0, m_stall = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {in_ready,out_valid,write_in,rotate_in,shift_out,z_a,z_b,z_c,en_a,en_b,en_c,busy,b_sel[3:0],c_sel[4:0]}
  function automatic logic [20:0] sample();
    return {bus.in_ready, bus.out_valid, bus.write_in, bus.rotate_in, bus.shift_out,
            bus.z_a_layer, bus.z_b_layer, bus.z_c_layer,
            bus.en_a_layer, bus.en_b_layer, bus.en_c_layer, bus.busy,
            bus.b_src_sel, bus.c_src_sel};
  endfunction

  function automatic logic [20:0] model_out(bit wv, bit hv, bit ir, bit rs);
    logic [20:0] v = '0;
    if (!m_busy) begin
      v[20] = wv;
      if (hv && wv && !rs) begin
        v[18] = 1'b1; v[15] = 1'b1; v[14] = 1'b1; v[13] = 1'b1;
      end
    end else begin
      v[9] = 1'b1;
      if (m_e <= IN_COLS) begin
        v[17] = 1'b1; v[12] = 1'b1;
      end else if (m_e <= IN_COLS + NA) begin
        v[11] = 1'b1; v[8:5] = 4'(m_e - IN_COLS - 1);
      end else if (m_e <= IN_COLS + NA + NB) begin
        v[10] = 1'b1; v[4:0] = 5'(m_e - IN_COLS - NA - 1);
      end else begin
        v[19] = 1'b1; v[16] = ir && wv && !rs;
      end
    end
    return v;
  endfunction

  task automatic model_update(input bit wv, input bit hv, input bit ir, input bit rs);
    if (rs) begin
      m_busy = 0; m_e = 0; m_frame = 0; m_stall = 0;
    end else if (!m_busy) begin
      if (hv && wv) begin m_busy = 1; m_e = 1; end
    end else begin
      if (m_e == LAT) begin
        if (!ir && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (ir && wv && m_frame != 32'hFFFF_FFFF) m_frame++;
      end
      if (!wv) m_busy = 0;
      else if (m_e == LAT) begin if (ir) m_busy = 0; end
      else m_e++;
    end
  endtask

  // One clock: drive, compare at negedge, advance model at posedge
  task automatic do_cycle(input bit wv, input bit hv, input bit ir, input bit rs,
                          output logic [20:0] got);
    logic [20:0] exp;
    bus.weight_valid  = wv;
    bus.heu_out_valid = hv;
    bus.iru_in_ready  = ir;
    rst               = rs;
    @(negedge clk);
    got = sample();
    exp = model_out(wv, hv, ir, rs);
    check($sformatf("cyc%0d outputs", cyc), 64'(got), 64'(exp));
`ifdef RDN_SCHED_PERF_EN
    check($sformatf("cyc%0d frame_cnt", cyc), 64'(frame_cnt), 64'(m_frame));
    check($sformatf("cyc%0d stall_cnt", cyc), 64'(stall_cnt), 64'(m_stall));
`endif
    @(posedge clk);
    model_update(wv, hv, ir, rs);
    cyc++;
    #1;
  endtask

  typedef struct {
    bit wv, hv, ir, rs;
    int n;
    int writes, rots, enbs, encs, outvs, shifts;
    bit busy_end;
  } seg_t;

  seg_t segs[18];

  initial begin
    logic [20:0] g;
    int w_cnt, r_cnt, b_cnt, c_cnt, o_cnt, s_cnt;
    int w_at[2], s_at[2], ov_at, ir_at;
`ifdef RDN_SCHED_PERF_EN
    logic [31:0] f0, s0;
`endif
    //        wv hv ir rs   n  wr rot enb enc outv sh busy_end
    segs[0]  = '{0, 1, 0, 0,  20, 0,  0,  0,  0, 0, 0, 0};  // no weights: never accept
    segs[1]  = '{1, 1, 1, 0,   1, 1,  0,  0,  0, 0, 0, 1};  // accept
    segs[2]  = '{1, 0, 1, 0, 126, 0, 80, 15, 30, 1, 1, 0};  // full frame, IRU ready
    segs[3]  = '{1, 0, 0, 0,   2, 0,  0,  0,  0, 0, 0, 0};
    segs[4]  = '{1, 1, 0, 0,   1, 1,  0,  0,  0, 0, 0, 1};  // accept
    segs[5]  = '{1, 0, 0, 0, 135, 0, 80, 15, 30,10, 0, 1};  // 10 stall cycles in OUT
    segs[6]  = '{1, 0, 1, 0,   1, 0,  0,  0,  0, 1, 1, 0};  // handshake
    segs[7]  = '{1, 1, 1, 0,   1, 1,  0,  0,  0, 0, 0, 1};  // accept
    segs[8]  = '{1, 0, 1, 0,  87, 0, 80,  7,  0, 0, 0, 1};  // up to B_RUN cnt=7
    segs[9]  = '{0, 0, 1, 0,   1, 0,  0,  1,  0, 0, 0, 0};  // weights drop -> abort
    segs[10] = '{1, 0, 1, 0, 130, 0,  0,  0,  0, 0, 0, 0};  // no result appears
    segs[11] = '{1, 1, 1, 0,   1, 1,  0,  0,  0, 0, 0, 1};  // accept
    segs[12] = '{1, 0, 1, 0, 100, 0, 80, 15,  5, 0, 0, 1};  // into C_RUN
    segs[13] = '{1, 0, 1, 1,   1, 0,  0,  0,  1, 0, 0, 0};  // reset mid C_RUN
    segs[14] = '{1, 0, 1, 0,   1, 0,  0,  0,  0, 0, 0, 0};  // quiet after reset
    segs[15] = '{1, 1, 1, 0,   1, 1,  0,  0,  0, 0, 0, 1};  // fresh accept
    segs[16] = '{1, 0, 1, 0, 126, 0, 80, 15, 30, 1, 1, 0};  // full frame again
    segs[17] = '{1, 1, 1, 0, 254, 2,160, 30, 60, 2, 2, 0};  // back-to-back frames

    bus.weight_valid  = 1'b0;
    bus.heu_out_valid = 1'b0;
    bus.iru_in_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // Reset state: everything 0 except in_ready following weight_valid
    check("reset wv0", 64'(sample()), 64'(0));
    bus.weight_valid = 1'b1;
    #1;
    check("reset wv1", 64'(sample()), 64'(21'h100000));
`ifdef RDN_SCHED_PERF_EN
    check("reset frame_cnt", 64'(frame_cnt), 64'(0));
    check("reset stall_cnt", 64'(stall_cnt), 64'(0));
`endif
    do_cycle(1, 0, 0, 1, g);  // one more reset cycle with model in sync

    for (int si = 0; si < 18; si++) begin
`ifdef RDN_SCHED_PERF_EN
      if (si == 4) begin f0 = frame_cnt; s0 = stall_cnt; end
`endif
      w_cnt = 0; r_cnt = 0; b_cnt = 0; c_cnt = 0; o_cnt = 0; s_cnt = 0;
      for (int k = 0; k < segs[si].n; k++) begin
        do_cycle(segs[si].wv, segs[si].hv, segs[si].ir, segs[si].rs, g);
        w_cnt += int'(g[18]); r_cnt += int'(g[17]); b_cnt += int'(g[11]);
        c_cnt += int'(g[10]); o_cnt += int'(g[19]); s_cnt += int'(g[16]);
      end
      check($sformatf("seg%0d write_in", si),  64'(w_cnt), 64'(segs[si].writes));
      check($sformatf("seg%0d rotate_in", si), 64'(r_cnt), 64'(segs[si].rots));
      check($sformatf("seg%0d en_b", si),      64'(b_cnt), 64'(segs[si].enbs));
      check($sformatf("seg%0d en_c", si),      64'(c_cnt), 64'(segs[si].encs));
      check($sformatf("seg%0d out_valid", si), 64'(o_cnt), 64'(segs[si].outvs));
      check($sformatf("seg%0d shift_out", si), 64'(s_cnt), 64'(segs[si].shifts));
      check($sformatf("seg%0d busy_end", si),  64'(bus.busy), 64'(segs[si].busy_end));
`ifdef RDN_SCHED_PERF_EN
      if (si == 6) begin
        check("perf frame delta", 64'(frame_cnt - f0), 64'(1));
        check("perf stall delta", 64'(stall_cnt - s0), 64'(10));
      end
`endif
    end

    // Hand-written timing: back-to-back windows, record event offsets
    w_at = '{-1, -1}; s_at = '{-1, -1}; ov_at = -1; ir_at = -1;
    w_cnt = 0; s_cnt = 0;
    for (int k = 0; k < 254; k++) begin
      do_cycle(1, 1, 1, 0, g);
      if (g[18] && w_cnt < 2) begin w_at[w_cnt] = k; w_cnt++; end
      if (g[16] && s_cnt < 2) begin s_at[s_cnt] = k; s_cnt++; end
      if (g[19] && ov_at < 0) ov_at = k;
      if (g[20] && k > 0 && ir_at < 0) ir_at = k;
    end
    check("b2b first write", 64'(w_at[0]), 64'(0));
    check("b2b out_valid latency", 64'(ov_at - w_at[0]), 64'(LAT));
    check("b2b shift latency", 64'(s_at[0] - w_at[0]), 64'(LAT));
    check("b2b in_ready back", 64'(ir_at - w_at[0]), 64'(LAT + 1));
    check("b2b second write gap", 64'(w_at[1] - s_at[0]), 64'(1));
    check("b2b second shift", 64'(s_at[1] - w_at[1]), 64'(LAT));

    // Randomized traffic against the model
    for (int k = 0; k < 4000; k++) begin
      do_cycle(($urandom_range(0, 299) != 0), $urandom_range(0, 1) == 1,
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 599) == 0), g);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
